// File: rtl/al422_write_ctrl.sv
// Write-side controller for an AL422 FIFO: frames a host byte stream into
// /WRST + /WE write bursts, with short-frame and idle-timeout recovery.
module al422_write_ctrl #(
   parameter int unsigned FRAME_BYTES    = 2048,
   parameter int unsigned WRST_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       in_clk,
   input  logic       in_nrst,
   input  logic       enable,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_sof,
   output logic       s_ready,
   output logic [7:0] al_data,
   output logic       al_nwe,
   output logic       al_nwrst,
   output logic       frame_done,
   output logic       err_short,
   output logic       err_timeout,
   output logic [7:0] frame_cnt,
   output logic       busy
);

   localparam int unsigned CntW  = $clog2(FRAME_BYTES + 1);
   localparam int unsigned WrstW = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;

   localparam logic [CntW-1:0]  LastCnt  = CntW'(FRAME_BYTES - 1);
   localparam logic [CntW-1:0]  OneCnt   = CntW'(1);
   localparam logic [WrstW-1:0] WrstLast = WrstW'(WRST_CYCLES - 1);
   localparam logic [15:0]      IdleLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StWrst,
      StFirst,
      StWrite
   } state_e;

   state_e           state_q;
   logic             rdy_en_q;
   logic [7:0]       hold_q;
   logic [7:0]       al_data_q;
   logic             al_nwe_q;
   logic             al_nwrst_q;
   logic             frame_done_q;
   logic             err_short_q;
   logic [7:0]       frame_cnt_q;
   logic [CntW-1:0]  byte_cnt_q;
   logic [WrstW-1:0] wrst_cnt_q;
   logic [15:0]      idle_cnt_q;

   logic accept;
   logic idle_expired;

   // rdy_en_q keeps s_ready low while in reset; it rises on the first edge after release.
   assign s_ready      = rdy_en_q & (((state_q == StIdle) & enable) | (state_q == StWrite));
   assign accept       = s_valid & s_ready;
   assign idle_expired = (state_q == StWrite) & ~accept & (idle_cnt_q == IdleLast);

   assign al_data     = al_data_q;
   assign al_nwe      = al_nwe_q;
   assign al_nwrst    = al_nwrst_q;
   assign frame_done  = frame_done_q;
   assign err_short   = err_short_q;
   assign err_timeout = idle_expired;
   assign frame_cnt   = frame_cnt_q;
   assign busy        = (state_q != StIdle);

   always_ff @(posedge in_clk or negedge in_nrst) begin
      if (!in_nrst) begin
         state_q      <= StIdle;
         rdy_en_q     <= 1'b0;
         hold_q       <= 8'h00;
         al_data_q    <= 8'h00;
         al_nwe_q     <= 1'b1;
         al_nwrst_q   <= 1'b1;
         frame_done_q <= 1'b0;
         err_short_q  <= 1'b0;
         frame_cnt_q  <= 8'h00;
         byte_cnt_q   <= '0;
         wrst_cnt_q   <= '0;
         idle_cnt_q   <= 16'h0000;
      end else begin
         rdy_en_q     <= 1'b1;
         al_nwe_q     <= 1'b1;
         al_nwrst_q   <= 1'b1;
         frame_done_q <= 1'b0;
         err_short_q  <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (accept && s_sof) begin
                  hold_q     <= s_data;
                  wrst_cnt_q <= '0;
                  al_nwrst_q <= 1'b0;
                  state_q    <= StWrst;
               end
            end

            StWrst: begin
               if (wrst_cnt_q == WrstLast) begin
                  byte_cnt_q <= OneCnt;
                  idle_cnt_q <= 16'h0000;
                  state_q    <= StFirst;
               end else begin
                  wrst_cnt_q <= wrst_cnt_q + 1'b1;
                  al_nwrst_q <= 1'b0;
               end
            end

            StFirst: begin
               al_nwe_q  <= 1'b0;
               al_data_q <= hold_q;
               state_q   <= StWrite;
            end

            StWrite: begin
               if (accept) begin
                  idle_cnt_q <= 16'h0000;
                  // A new SOF wins over completion: the byte restarts the frame uncounted.
                  if (s_sof) begin
                     hold_q      <= s_data;
                     wrst_cnt_q  <= '0;
                     al_nwrst_q  <= 1'b0;
                     err_short_q <= 1'b1;
                     state_q     <= StWrst;
                  end else begin
                     al_nwe_q   <= 1'b0;
                     al_data_q  <= s_data;
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                     if (byte_cnt_q == LastCnt) begin
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + 8'd1;
                        state_q      <= StIdle;
                     end
                  end
               end else if (idle_expired) begin
                  state_q <= StIdle;
               end else begin
                  idle_cnt_q <= idle_cnt_q + 16'd1;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_al422_write_ctrl.sv
// Directed bench for al422_write_ctrl with FRAME_BYTES=4, WRST_CYCLES=2, TIMEOUT_CYCLES=8.
module tb_al422_write_ctrl;

   localparam int unsigned FB = 4;
   localparam int unsigned WR = 2;
   localparam int unsigned TO = 8;

   logic       in_clk;
   logic       in_nrst;
   logic       enable;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_sof;
   logic       s_ready;
   logic [7:0] al_data;
   logic       al_nwe;
   logic       al_nwrst;
   logic       frame_done;
   logic       err_short;
   logic       err_timeout;
   logic [7:0] frame_cnt;
   logic       busy;

   al422_write_ctrl #(
      .FRAME_BYTES   (FB),
      .WRST_CYCLES   (WR),
      .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .in_clk     (in_clk),
      .in_nrst    (in_nrst),
      .enable     (enable),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_sof      (s_sof),
      .s_ready    (s_ready),
      .al_data    (al_data),
      .al_nwe     (al_nwe),
      .al_nwrst   (al_nwrst),
      .frame_done (frame_done),
      .err_short  (err_short),
      .err_timeout(err_timeout),
      .frame_cnt  (frame_cnt),
      .busy       (busy)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed activity, sampled on the falling edge.
   int          cyc, n_wr, n_rstlow, n_rstp, n_done, n_short, n_tout, n_viol, n_lat, n_ord;
   int          first_wr_cyc, last_wr_cyc, first_rst_cyc, sof_acc_cyc, last_acc_cyc;
   int          done_cyc, tout_cyc, rdy_block;
   logic [63:0] wr_pack;
   logic        prev_nwrst, p_acc, p_sof, chk_lat;
   logic [7:0]  p_data;
   logic [7:0]  exp_q[$];

   task automatic clear_stats();
      n_wr = 0; n_rstlow = 0; n_rstp = 0; n_done = 0; n_short = 0; n_tout = 0;
      n_viol = 0; n_lat = 0; n_ord = 0;
      first_wr_cyc = -1; last_wr_cyc = -1; first_rst_cyc = -1; sof_acc_cyc = -1;
      last_acc_cyc = -1; done_cyc = -1; tout_cyc = -1; rdy_block = 0;
      wr_pack = '0; prev_nwrst = 1'b1; p_acc = 1'b0; p_sof = 1'b0; p_data = 8'h00;
      exp_q.delete();
   endtask

   always @(negedge in_clk) begin
      if (in_nrst) begin
         logic acc;
         cyc++;
         if (!al_nwe) begin
            n_wr++;
            wr_pack = {wr_pack[55:0], al_data};
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            if (chk_lat) begin
               if (exp_q.size() == 0) n_ord++;
               else if (exp_q.pop_front() != al_data) n_ord++;
            end
         end
         if (!al_nwrst) begin
            n_rstlow++;
            if (prev_nwrst) n_rstp++;
            if (first_rst_cyc < 0) first_rst_cyc = cyc;
         end
         prev_nwrst = al_nwrst;
         if (frame_done) begin
            n_done++;
            done_cyc = cyc;
            if (al_nwe) n_viol++;
         end
         if (err_short) n_short++;
         if (err_timeout) begin
            n_tout++;
            tout_cyc = cyc;
         end
         if (!al_nwe && !al_nwrst) n_viol++;
         if (int'(frame_done) + int'(err_short) + int'(err_timeout) > 1) n_viol++;
         if (rdy_block > 0) begin
            if (s_ready) n_viol++;
            rdy_block--;
         end
         if (chk_lat && p_acc && !p_sof && (al_nwe || al_data != p_data)) n_lat++;
         acc = s_valid & s_ready;
         if (acc) begin
            last_acc_cyc = cyc;
            if (s_sof) begin
               rdy_block = WR + 1;
               if (sof_acc_cyc < 0) sof_acc_cyc = cyc;
            end
         end
         p_acc  = acc;
         p_sof  = s_sof;
         p_data = s_data;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge in_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic sof);
      int w;
      w       = 0;
      s_data  = d;
      s_sof   = sof;
      s_valid = 1'b1;
      @(negedge in_clk);
      while (!s_ready && w < 50) begin
         w++;
         @(negedge in_clk);
      end
      if (w == 50) check("push_ready", {63'b0, s_ready}, 64'd1);
      @(posedge in_clk);
      #1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge in_clk);
      #2 in_nrst = 1'b0;
      @(negedge in_clk);
      #2 in_nrst = 1'b1;
      clear_stats();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      cyc = 0; chk_lat = 1'b0;
      clear_stats();
      in_nrst = 1'b0; enable = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_sof = 1'b0;

      // Reset values while in_nrst is held low with enable high.
      #12;
      check("rst_s_ready", {63'b0, s_ready}, 64'd0);
      check("rst_al_data", {56'b0, al_data}, 64'h00);
      check("rst_al_nwe", {63'b0, al_nwe}, 64'd1);
      check("rst_al_nwrst", {63'b0, al_nwrst}, 64'd1);
      check("rst_flags", {61'b0, frame_done, err_short, err_timeout}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_frame_cnt", {56'b0, frame_cnt}, 64'd0);
      @(negedge in_clk);
      #2 in_nrst = 1'b1;
      @(negedge in_clk);
      check("ready_after_rst", {63'b0, s_ready}, 64'd1);
      enable = 1'b0;
      #1 check("ready_enable_low", {63'b0, s_ready}, 64'd0);
      enable = 1'b1;
      clear_stats();
      idle(1);

      // Nominal frame; enable dropped mid-frame must not matter.
      push(8'hA0, 1'b1);
      enable = 1'b0;
      push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0);
      idle(3);
      check("s1_writes", n_wr, 4);
      check("s1_data", wr_pack, 64'hA0A1A2A3);
      check("s1_wrst_pulses", n_rstp, 1);
      check("s1_wrst_len", n_rstlow, WR);
      check("s1_wrst_start", first_rst_cyc - sof_acc_cyc, 1);
      check("s1_first_write", first_wr_cyc - first_rst_cyc, WR + 1);
      check("s1_consecutive", last_wr_cyc - first_wr_cyc, FB - 1);
      check("s1_done_cnt", n_done, 1);
      check("s1_done_with_last", done_cyc, last_wr_cyc);
      check("s1_frame_cnt", {56'b0, frame_cnt}, 64'd1);
      check("s1_busy", {63'b0, busy}, 64'd0);
      check("s1_viol", n_viol, 0);
      enable = 1'b1;

      // Pre-SOF garbage is discarded.
      do_reset();
      push(8'h55, 1'b0); push(8'h66, 1'b0);
      push(8'hA0, 1'b1); push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0);
      idle(3);
      check("s2_writes", n_wr, 4);
      check("s2_data", wr_pack, 64'hA0A1A2A3);
      check("s2_wrst_pulses", n_rstp, 1);
      check("s2_frame_cnt", {56'b0, frame_cnt}, 64'd1);

      // Short frame interrupted by a new SOF.
      do_reset();
      push(8'hA0, 1'b1); push(8'hA1, 1'b0);
      push(8'hB0, 1'b1); push(8'hB1, 1'b0); push(8'hB2, 1'b0); push(8'hB3, 1'b0);
      idle(3);
      check("s3_short", n_short, 1);
      check("s3_writes", n_wr, 6);
      check("s3_data", wr_pack, 64'h0000A0A1B0B1B2B3);
      check("s3_wrst_pulses", n_rstp, 2);
      check("s3_done", n_done, 1);
      check("s3_frame_cnt", {56'b0, frame_cnt}, 64'd1);
      check("s3_viol", n_viol, 0);

      // Idle timeout inside a frame.
      do_reset();
      push(8'hA0, 1'b1); push(8'hA1, 1'b0);
      idle(10);
      check("s4_tout", n_tout, 1);
      check("s4_tout_delay", tout_cyc - last_acc_cyc, TO);
      check("s4_busy", {63'b0, busy}, 64'd0);
      check("s4_wrst_pulses", n_rstp, 1);
      check("s4_done_short", n_done + n_short, 0);
      push(8'hC0, 1'b1);
      idle(3);
      check("s4_new_wrst", n_rstp, 2);
      check("s4_busy_again", {63'b0, busy}, 64'd1);

      // Back-pressure across 256 frames with frame counter wrap.
      do_reset();
      chk_lat = 1'b1;
      for (int f = 0; f < 256; f++) begin
         for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'(f * 4 + i);
            exp_q.push_back(b);
            push(b, i == 0);
            idle(1);
         end
      end
      idle(3);
      chk_lat = 1'b0;
      check("s5_latency", n_lat, 0);
      check("s5_order", n_ord, 0);
      check("s5_left", exp_q.size(), 0);
      check("s5_writes", n_wr, 1024);
      check("s5_done", n_done, 256);
      check("s5_wrst_pulses", n_rstp, 256);
      check("s5_viol", n_viol, 0);
      check("s5_frame_cnt", {56'b0, frame_cnt}, 64'd0);

      // Reset pulsed mid-frame.
      do_reset();
      push(8'hA0, 1'b1); push(8'hA1, 1'b0);
      @(negedge in_clk);
      check("s6_a1_written", {55'b0, al_nwe, al_data}, {55'b0, 1'b0, 8'hA1});
      #2 in_nrst = 1'b0;
      #1;
      check("s6_nwe", {63'b0, al_nwe}, 64'd1);
      check("s6_nwrst", {63'b0, al_nwrst}, 64'd1);
      check("s6_flags", {61'b0, frame_done, err_short, err_timeout}, 64'd0);
      check("s6_busy", {63'b0, busy}, 64'd0);
      check("s6_frame_cnt", {56'b0, frame_cnt}, 64'd0);
      @(negedge in_clk);
      #2 in_nrst = 1'b1;
      clear_stats();
      push(8'hD0, 1'b1); push(8'hD1, 1'b0); push(8'hD2, 1'b0); push(8'hD3, 1'b0);
      idle(3);
      check("s6_wrst_pulses", n_rstp, 1);
      check("s6_wrst_len", n_rstlow, WR);
      check("s6_writes", n_wr, 4);
      check("s6_data", wr_pack, 64'hD0D1D2D3);
      check("s6_errs", n_short + n_tout, 0);
      check("s6_frame_cnt", {56'b0, frame_cnt}, 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
